alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the combinational ALU-control decode. Decodes {alu_op,func7,func3} to a 4-bit ALU code and executes it on XLEN-bit operands.
//  Single-cycle ops finish in 1 cycle; shifts iterate 1 bit/cycle; optional MUL iterates shift-add.
//  Sits in the execute stage. Valid/ready handshake on input and output lets the core stall on multi-cycle ops.
// PARAMETERS
//  XLEN   32  operand/result width, power of 2, >=8
//  SHW    5   shift-amount width = log2(XLEN)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operation request
//  in_ready   out  1     unit can accept request
//  alu_op     in   2     00 load/store, 01 branch, 10 R-type, 11 I-type
//  func7      in   2     {instr[30], instr[25]}
//  func3      in   3     instr[14:12]
//  op_a       in   XLEN  operand A
//  op_b       in   XLEN  operand B / immediate; shamt = op_b[SHW-1:0]
//  flush      in   1     abandon current op
//  out_valid  out  1     result available
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result
//  zero       out  1     result == 0
//  alu_ctrl   out  4     decoded code of the op in flight
//  illegal    out  1     decode failed (qualified by out_valid)
// BEHAVIOUR
//  Decode: 00->ADD 0010; 01->SUB 0110; 10/11 use func3.
//   000: ADD, or SUB if alu_op=10 and func7[1]. 111 AND 0000, 110 OR 0001, 100 XOR 0011, 010 SLT 0100, 011 SLTU 0101.
//   001 SLL 1000. 101: SRL 1001 if func7[1]=0, else SRA 1011.
//   alu_op=10 and func7=01 -> MUL 1100 (func3=000 only, see CONFIGURATION). Any other combination -> 1111, illegal.
//  Reset: state IDLE; in_ready=0 while rst_n low, then 1. out_valid, result, zero, alu_ctrl, illegal all 0.
//  FSM states: IDLE, SHIFT, MUL, DONE.
//   IDLE: in_ready = ~flush. Accept on in_valid & in_ready; latch operands and code.
//     Single-cycle, illegal or shamt==0 -> DONE. Shift -> SHIFT. MUL -> MUL.
//   SHIFT: 1 bit/cycle; count = shamt; -> DONE once count reaches 0. SRA replicates the MSB.
//   MUL: XLEN shift-add iterations, one per cycle; -> DONE.
//   DONE: out_valid=1; result/zero/alu_ctrl/illegal held stable while out_ready=0. out_ready -> IDLE.
//  Latency (accept edge to out_valid): 1 cycle for single-cycle ops; 1+shamt for shifts; 1+XLEN for MUL.
//  in_ready=0 in SHIFT, MUL and DONE. No back-to-back acceptance; throughput for single-cycle ops is 1 op per 2 cycles.
//  Arithmetic: ADD/SUB/MUL wrap mod 2^XLEN, low XLEN bits kept. SLT signed, SLTU unsigned; both give 0/1 zero-extended.
//  Illegal op: result=0, zero=1, alu_ctrl=1111, illegal=1.
//  flush: in any state -> IDLE next edge; out_valid=0; in-flight op discarded.
//   flush together with in_valid: request not accepted.
//   flush in DONE together with out_ready: the result is lost; the consumer must ignore it.
//  Reset asserted mid-operation: immediate return to reset values; no partial result is exposed.
// CONFIGURATION
//  MUL_EXT_EN defined: MUL decoded (code 1100) and executed by an iterative multiplier, low XLEN bits of op_a*op_b.
//  MUL_EXT_EN undefined: the MUL encoding decodes as illegal (1111); MUL state and datapath are not built.
// TESTING
//  T1 alu_op=10,func7=10,func3=000,a=5,b=5 -> out_valid 1 cycle after accept; result=0, zero=1, alu_ctrl=0110.
//  T2 alu_op=10,func7=10,func3=101,a=32'h8000_0000,b=4 -> out_valid 5 cycles after accept; result=32'hF800_0000, ctrl=1011.
//  T3 ADD 3+4 with out_ready=0 for 3 cycles -> result 7 held stable, in_ready=0 throughout; dequeued on out_ready=1.
//  T4 SLL shamt=20, flush 3 cycles after accept -> out_valid never rises; IDLE next cycle; following ADD 1+1 returns 2.
//  T5 alu_op=10,func7=00,func3=011,a=-1,b=1 -> SLTU result=0; same inputs with func3=010 (SLT) -> result=1.
//  T6 alu_op=10,func7=01,func3=000,a=7,b=6 -> with MUL_EXT_EN: result=42 after 1+XLEN cycles; without: illegal=1, ctrl=1111.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with decode of {alu_op,func7,func3}.
// Single-cycle logic/arith ops, iterative 1 bit/cycle shifts, and an
// optional iterative shift-add multiplier enabled by defining MUL_EXT_EN.
// Valid/ready handshake on both sides; flush abandons the op in flight.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [1:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLT  = 4'b0100;
  localparam logic [3:0] C_SLTU = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_MUL  = 4'b1100;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Map the instruction fields onto the 4-bit ALU code.
  function automatic logic [3:0] decode(input logic [1:0] op, input logic [1:0] f7,
                                        input logic [2:0] f3);
    logic [3:0] c;
    c = C_ILL;
    if (op == 2'b00) begin
      c = C_ADD;
    end else if (op == 2'b01) begin
      c = C_SUB;
    end else if ((op == 2'b10) && f7[0]) begin
`ifdef MUL_EXT_EN
      c = (f3 == 3'b000) ? C_MUL : C_ILL;
`else
      c = C_ILL;
`endif
    end else begin
      case (f3)
        3'b000:  c = ((op == 2'b10) && f7[1]) ? C_SUB : C_ADD;
        3'b001:  c = C_SLL;
        3'b010:  c = C_SLT;
        3'b011:  c = C_SLTU;
        3'b100:  c = C_XOR;
        3'b101:  c = f7[1] ? C_SRA : C_SRL;
        3'b110:  c = C_OR;
        3'b111:  c = C_AND;
        default: c = C_ILL;
      endcase
    end
    return c;
  endfunction

  // One-cycle result; shift codes only reach here with a zero shift amount.
  function automatic logic [XLEN-1:0] exec1(input logic [3:0] c, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (c)
      C_AND:   r = a & b;
      C_OR:    r = a | b;
      C_ADD:   r = a + b;
      C_XOR:   r = a ^ b;
      C_SUB:   r = a - b;
      C_SLT:   r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLTU:  r = {{(XLEN-1){1'b0}}, (a < b)};
      C_SLL:   r = a;
      C_SRL:   r = a;
      C_SRA:   r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One step of the iterative shifter; SRA refills with the sign bit.
  function automatic logic [XLEN-1:0] shift1(input logic [3:0] c, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (c)
      C_SLL:   r = {v[XLEN-2:0], 1'b0};
      C_SRL:   r = {1'b0, v[XLEN-1:1]};
      C_SRA:   r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            rdy_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            ill_q, ill_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      dec_s;
  logic            accept_s;
  logic            is_shift_s;
  logic [SHW-1:0]  shamt_s;
`ifdef MUL_EXT_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
`endif

  assign dec_s      = decode(alu_op, func7, func3);
  assign accept_s   = in_valid && in_ready;
  assign shamt_s    = op_b[SHW-1:0];
  assign is_shift_s = (dec_s == C_SLL) || (dec_s == C_SRL) || (dec_s == C_SRA);

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ctrl_q   <= 4'b0000;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef MUL_EXT_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      result_q <= result_d;
      zero_q   <= zero_d;
      ctrl_q   <= ctrl_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
`ifdef MUL_EXT_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  // Next-state: flush wins everywhere, otherwise accept/iterate/dequeue.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (is_shift_s && (shamt_s != '0)) begin
              state_d = S_SHIFT;
`ifdef MUL_EXT_EN
            end else if (dec_s == C_MUL) begin
              state_d = S_MUL;
`endif
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
`ifdef MUL_EXT_EN
        S_MUL: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs; in_ready stays low until the first edge after reset.
  always_comb begin
    if (rdy_q && (state_q == S_IDLE) && !flush) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    out_valid = (state_q == S_DONE);
  end

  // Datapath: latch on accept, then step the shifter or multiplier.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
`ifdef MUL_EXT_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ctrl_d = dec_s;
          ill_d  = (dec_s == C_ILL);
          if (is_shift_s && (shamt_s != '0)) begin
            result_d = op_a;
            cnt_d    = shamt_s;
`ifdef MUL_EXT_EN
          end else if (dec_s == C_MUL) begin
            result_d = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = SHW'(XLEN - 1);
`endif
          end else begin
            result_d = exec1(dec_s, op_a, op_b);
          end
          zero_d = (result_d == '0);
        end else begin
          result_d = result_q;
        end
      end
      S_SHIFT: begin
        result_d = shift1(ctrl_q, result_q);
        cnt_d    = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        zero_d   = (result_d == '0);
      end
`ifdef MUL_EXT_EN
      S_MUL: begin
        result_d = result_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        cnt_d    = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        zero_d   = (result_d == '0);
      end
`endif
      default: begin
        result_d = result_q;
      end
    endcase
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign alu_ctrl = ctrl_q;
  assign illegal  = ill_q;

endmodule
